ca5_frame_tx: RTL

Transmit end of the CA5 serial link. On `start` it first drives a calibration pulse on `adjust`, one bit-period wide. It then shifts out n+1 data words MSB-first on `sdo`, each bit held for one bit period. The CA5 receive controller uses the adjust width to time its bit sampling and its word counter to raise `valid` after word n. This block sits between the word source (handshake via `data_req`) and the serial line.

---
 rtl/ca5_pkg.sv | 19 +
 rtl/ca5_bit_timer.sv | 38 +++
 rtl/ca5_frame_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ca5_pkg.sv
// Shared definitions for the CA5 serial link: state encoding and default widths.
package ca5_pkg;

  localparam int CA5_DATA_W = 8;
  localparam int CA5_DIV_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJ    = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } ca5_state_t;

  // Width of a counter that indexes bits 0..w-1 (at least one bit).
  function automatic int ca5_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ca5_bit_timer.sv
// Bit-period tick counter. Latches the divider on load, counts 0..div while
// enabled and wraps; o_last marks the final cycle of a bit period.
module ca5_bit_timer #(
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_en,
  output logic             o_last
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_tick;

  // Divider latch and tick counter; the tick is held at zero whenever not counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_tick <= '0;
    end else if (i_load) begin
      r_div  <= i_div;
      r_tick <= '0;
    end else if (i_en) begin
      if (o_last) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_tick <= '0;
    end
  end

  assign o_last = (r_tick == r_div);

endmodule

// File: rtl/ca5_frame_tx.sv
// CA5 frame transmitter: calibration pulse on o_adjust, then n+1 words
// shifted MSB-first on o_sdo, one bit per bit period, words back-to-back.
module ca5_frame_tx
  import ca5_pkg::*;
#(
  parameter int DATA_W = CA5_DATA_W,
  parameter int DIV_W  = CA5_DIV_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_n,
  input  logic [DIV_W-1:0]  i_bit_div,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_data_req,
  output logic              o_adjust,
  output logic              o_sdo,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = ca5_cnt_w(DATA_W);

  ca5_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [2:0]        r_word_cnt;
  logic [2:0]        r_word_max;
  logic              r_adjust;
  logic              r_sdo;
  logic              r_busy;
  logic              r_done;

  logic w_timer_load;
  logic w_timer_en;
  logic w_last;
  logic w_last_bit;
  logic w_last_word;
  logic w_data_req;

  ca5_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_timer_load),
    .i_div  (i_bit_div),
    .i_en   (w_timer_en),
    .o_last (w_last)
  );

  // Timer control, end-of-bit/word decode and the word-consume strobe.
  always_comb begin
    w_timer_load = (r_state == IDLE) && i_start;
    w_timer_en   = (r_state == ADJ) || (r_state == SHIFT);
    w_last_bit   = (r_bit_cnt == CNT_W'(DATA_W - 1));
    w_last_word  = (r_word_cnt == r_word_max);
    w_data_req   = 1'b0;
    if (i_rst) begin
      w_data_req = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_data_req = i_start;
        SHIFT:   w_data_req = w_last && w_last_bit && !w_last_word;
        default: w_data_req = 1'b0;
      endcase
    end
  end

  // Frame FSM with shift register, word counter and registered line outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= 3'd0;
      r_word_max <= 3'd0;
      r_adjust   <= 1'b0;
      r_sdo      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= ADJ;
            r_word_max <= i_n;
            r_shift    <= i_data_in;
            r_bit_cnt  <= '0;
            r_word_cnt <= 3'd0;
            r_adjust   <= 1'b1;
            r_sdo      <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        ADJ: begin
          if (w_last) begin
            r_state  <= SHIFT;
            r_adjust <= 1'b0;
            r_sdo    <= r_shift[DATA_W-1];
          end
        end
        SHIFT: begin
          if (w_last) begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              if (w_last_word) begin
                r_state <= FINISH;
                r_sdo   <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // Next word follows immediately, no idle bit between words.
                r_shift    <= i_data_in;
                r_sdo      <= i_data_in[DATA_W-1];
                r_word_cnt <= r_word_cnt + 3'd1;
              end
            end else begin
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
              r_sdo     <= r_shift[DATA_W-2];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_sdo   <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_adjust <= 1'b0;
          r_sdo    <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_req = w_data_req;
  assign o_adjust   = r_adjust;
  assign o_sdo      = r_sdo;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
